// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : MEM/WB writeback stage. Selects the writeback value, commits it
// to the register file, and latches a sticky halt that freezes all state.
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_v,
  input  logic [DATA_W-1:0] alu_v,
  input  logic [ADDR_W-1:0] rW,
  input  logic              rw_en,
  input  logic              memread,
  input  logic              hault,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rA_data,
  output logic [DATA_W-1:0] rB_data,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS] = '{default: '0};
  logic              halted_q      = 1'b0;
  logic [CNT_W-1:0]  cycle_cnt_q   = '0;
  logic [CNT_W-1:0]  wb_cnt_q      = '0;

  logic              halted_d;
  logic [CNT_W-1:0]  cycle_cnt_d;
  logic [CNT_W-1:0]  wb_cnt_d;
  logic              we;

  assign wb_data = memread ? mem_v : alu_v;
  assign we      = rw_en && (rW != '0) && !halted_q;

  // Read ports see a write in flight the same cycle it is presented.
  always_comb begin
    rA_data  = '0;
    rB_data  = '0;
    dbg_data = '0;
    if (rA != '0)       rA_data  = (we && rA == rW)       ? wb_data : regs_q[rA];
    if (rB != '0)       rB_data  = (we && rB == rW)       ? wb_data : regs_q[rB];
    if (dbg_addr != '0) dbg_data = (we && dbg_addr == rW) ? wb_data : regs_q[dbg_addr];
  end

  always_comb begin
    halted_d    = halted_q | hault;
    cycle_cnt_d = halted_q ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    wb_cnt_d    = we ? wb_cnt_q + CNT_W'(1) : wb_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      halted_q    <= 1'b0;
      cycle_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      if (we) regs_q[rW] <= wb_data;
      halted_q    <= halted_d;
      cycle_cnt_q <= cycle_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign cycle_cnt = cycle_cnt_q;
  assign wb_cnt    = wb_cnt_q;

endmodule

`default_nettype wire
